// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_t : arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   owner_t     : requester index (0 = cpu, 1 = loader/DMA)
//   ARB_PORTS   : number of requesters
package mem_arb_pkg;

  localparam int unsigned ARB_PORTS = 2;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_CPU    = 1'b0;
  localparam owner_t OWNER_LOADER = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational two-way round-robin pick.
// Ports:
//   req        in   [1:0]  request vector, bit N = port N
//   last_owner in   1      port that received the most recent grant
//   winner     out  1      chosen port (meaningful only when valid)
//   valid      out  1      at least one request is present
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [ARB_PORTS-1:0] req,
  input  owner_t               last_owner,
  output owner_t               winner,
  output logic                 valid
);

  always_comb begin
    valid  = |req;
    winner = OWNER_CPU;
    if (req[0] && req[1]) begin
      // On contention the port that did not go last wins, so grants alternate.
      winner = owner_t'(~last_owner);
    end else if (req[1]) begin
      winner = OWNER_LOADER;
    end else begin
      winner = OWNER_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between port 0 (cpu) and port 1 (loader/DMA).
// One access per grant, round-robin on contention, registered memory-side outputs.
// Optional feature: define MEM_ARB_BURST_EN to let the current owner keep the bus for up to
// MAX_BURST back-to-back grants while it keeps requesting.
// Ports:
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   rN_req/rN_we/rN_addr/rN_wdata    request from port N, held stable until rN_gnt
//   rN_gnt                           one-cycle pulse: port N's access is on the memory bus
//   rN_rdata/rN_rvalid               read data, pulse valid the cycle after a read grant
//   mem_we/mem_addr/mem_wdata        registered memory controls
//   mem_rdata                        combinational memory read data
//   busy                             high while in ARB_GRANT
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t state_q, state_d;
  owner_t     last_owner_q, last_owner_d;

  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [ARB_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]        rdata0_q, rdata0_d;
  logic [DW-1:0]        rdata1_q, rdata1_d;

  logic [ARB_PORTS-1:0] req_vec;
  owner_t               rr_winner;
  logic                 rr_valid;

  owner_t        sel_owner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic stay_grant;
  logic grant_read;

  assign req_vec = {r1_req, r0_req};

  mem_arb_rr u_rr (
    .req        (req_vec),
    .last_owner (last_owner_q),
    .winner     (rr_winner),
    .valid      (rr_valid)
  );

  // In IDLE the round-robin winner is loaded; during a burst the current owner reloads.
  assign sel_owner = (state_q == ARB_IDLE) ? rr_winner : last_owner_q;

  always_comb begin
    if (sel_owner == OWNER_LOADER) begin
      sel_we    = r1_we;
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
    end else begin
      sel_we    = r0_we;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
    end
  end

`ifdef MEM_ARB_BURST_EN
  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  // Counts extra grants taken in the current burst (0 on the first grant).
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  assign stay_grant = (state_q == ARB_GRANT) && req_vec[last_owner_q] &&
                      (32'(burst_cnt_q) < (MAX_BURST - 1));

  always_comb begin
    burst_cnt_d = '0;
    if (stay_grant) begin
      burst_cnt_d = burst_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  // Without bursts every grant returns to IDLE; MAX_BURST has no effect.
  assign stay_grant = (MAX_BURST == 0) & 1'b0;
`endif

  // Next state and memory-side register loads.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (rr_valid) begin
          state_d      = ARB_GRANT;
          last_owner_d = rr_winner;
          mem_we_d     = sel_we;
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
        end
      end
      ARB_GRANT: begin
        if (stay_grant) begin
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Read data is sampled at the end of the grant cycle; each port's copy holds until its next read.
  assign grant_read = (state_q == ARB_GRANT) && !mem_we_q;

  always_comb begin
    rvalid_d    = '0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    if (grant_read) begin
      if (last_owner_q == OWNER_LOADER) begin
        rvalid_d[1] = 1'b1;
        rdata1_d    = mem_rdata;
      end else begin
        rvalid_d[0] = 1'b1;
        rdata0_d    = mem_rdata;
      end
    end
  end

  // A reset in the grant cycle still lets the RAM take the write on this edge,
  // because mem_we is already high; only the arbiter's own state is cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWNER_LOADER;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rvalid_q     <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rvalid_q     <= rvalid_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign busy      = (state_q == ARB_GRANT);
  assign r0_gnt    = busy && (last_owner_q == OWNER_CPU);
  assign r1_gnt    = busy && (last_owner_q == OWNER_LOADER);
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a transaction-level reference model
// and a per-cycle comparison, plus hand-computed literal expectations.
// Define MEM_ARB_BURST_EN for both bench and DUT to exercise bursts.
module tb_mem_arbiter;

  localparam int unsigned AW        = 8;
  localparam int unsigned DW        = 8;
  localparam int unsigned MAX_BURST = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          r0_req = 1'b0, r0_we = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] ram [256];

  always #5 clock = ~clock;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  mem_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rdata  (r0_rdata),
    .r0_rvalid (r0_rvalid),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rdata  (r1_rdata),
    .r1_rvalid (r1_rvalid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Tracks the access occupying the upcoming cycle (if any) and what it leaves behind.
  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic [DW-1:0] shadow [256];
  bit            m_ready = 1'b0;
  bit            m_grant = 1'b0;
  bit            m_last  = 1'b1;
  int            m_run   = 0;
  txn_t          m_cur;
  logic [1:0]    e_rvalid = '0;
  logic [DW-1:0] e_rdata0 = '0, e_rdata1 = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;

  function automatic txn_t fields_of(logic p);
    txn_t t;
    t.port  = p;
    t.we    = p ? r1_we : r0_we;
    t.addr  = p ? r1_addr : r0_addr;
    t.wdata = p ? r1_wdata : r0_wdata;
    return t;
  endfunction

  always @(posedge clock) begin
    bit   have;
    txn_t nxt;
    // The access of the cycle now ending takes effect at this edge, reset or not.
    e_rvalid = '0;
    if (m_grant && m_cur.we) shadow[m_cur.addr] = m_cur.wdata;
    if (reset) begin
      m_grant  = 1'b0;
      m_last   = 1'b1;
      m_run    = 0;
      e_rdata0 = '0;
      e_rdata1 = '0;
      e_addr   = '0;
      e_wdata  = '0;
    end else begin
      if (m_grant && !m_cur.we) begin
        if (m_cur.port) begin
          e_rvalid[1] = 1'b1;
          e_rdata1    = shadow[m_cur.addr];
        end else begin
          e_rvalid[0] = 1'b1;
          e_rdata0    = shadow[m_cur.addr];
        end
      end
      have = 1'b0;
      nxt  = '0;
      if (m_grant) begin
`ifdef MEM_ARB_BURST_EN
        if ((m_cur.port ? r1_req : r0_req) && m_run < int'(MAX_BURST)) begin
          have = 1'b1;
          nxt  = fields_of(m_cur.port);
        end
`endif
      end else if (r0_req || r1_req) begin
        have = 1'b1;
        nxt  = fields_of((r0_req && r1_req) ? !m_last : r1_req);
      end
      if (have) begin
        m_run   = m_grant ? m_run + 1 : 1;
        m_cur   = nxt;
        m_last  = nxt.port;
        e_addr  = nxt.addr;
        e_wdata = nxt.wdata;
      end else begin
        m_run = 0;
      end
      m_grant = have;
    end
    m_ready = 1'b1;
  end

  always @(negedge clock) begin
    if (m_ready) begin
      chk("r0_gnt", r0_gnt, m_grant && !m_cur.port);
      chk("r1_gnt", r1_gnt, m_grant && m_cur.port);
      chk("busy", busy, m_grant);
      chk("mem_we", mem_we, m_grant && m_cur.we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("r0_rvalid", r0_rvalid, e_rvalid[0]);
      chk("r1_rvalid", r1_rvalid, e_rvalid[1]);
      chk("r0_rdata", r0_rdata, e_rdata0);
      chk("r1_rdata", r1_rdata, e_rdata1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  int gq[$];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 8'(i) ^ 8'hA5;
      shadow[i] = 8'(i) ^ 8'hA5;
    end
    ram[8'h10]    = 8'h5A;
    shadow[8'h10] = 8'h5A;

    step();
    reset_pulse();
    chk("reset_busy", busy, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_r0_rvalid", r0_rvalid, 0);

    // Single read of 0x10 by port 0.
    r0_we = 1'b0; r0_addr = 8'h10; r0_req = 1'b1;
    step();
    chk("read_r0_gnt", r0_gnt, 1);
    chk("read_mem_addr", mem_addr, 8'h10);
    r0_req = 1'b0;
    step();
    chk("read_r0_rvalid", r0_rvalid, 1);
    chk("read_r0_rdata", r0_rdata, 8'h5A);
    step();
    chk("read_rvalid_pulse", r0_rvalid, 0);
    chk("read_rdata_hold", r0_rdata, 8'h5A);

    // Port 1 writes 0x33 to 0xF2, then reads it back.
    r1_we = 1'b1; r1_addr = 8'hF2; r1_wdata = 8'h33; r1_req = 1'b1;
    step();
    chk("wr_r1_gnt", r1_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wdata", mem_wdata, 8'h33);
    r1_req = 1'b0;
    step();
    chk("wr_mem_we_low", mem_we, 0);
    chk("wr_no_rvalid", r1_rvalid, 0);
    chk("wr_ram", ram[8'hF2], 8'h33);
    r1_we = 1'b0; r1_req = 1'b1;
    step();
    chk("rd_r1_gnt", r1_gnt, 1);
    r1_req = 1'b0;
    step();
    chk("rd_r1_rvalid", r1_rvalid, 1);
    chk("rd_r1_rdata", r1_rdata, 8'h33);

    // Contention from reset with both ports held.
    reset_pulse();
    r0_we = 1'b0; r0_addr = 8'h20; r0_req = 1'b1;
    r1_we = 1'b0; r1_addr = 8'h21; r1_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("both_gnt", r0_gnt & r1_gnt, 0);
      if (r0_gnt) gq.push_back(0);
      if (r1_gnt) gq.push_back(1);
    end
    r0_req = 1'b0; r1_req = 1'b0;
`ifdef MEM_ARB_BURST_EN
    chk("burst_len", gq.size(), 7);
    for (int k = 0; k < 4; k++) chk("burst_r0", gq[k], 0);
    chk("burst_then_r1", gq[4], 1);
`else
    chk("cont_len", gq.size(), 4);
    chk("cont_g0", gq[0], 0);
    chk("cont_g1", gq[1], 1);
    chk("cont_g2", gq[2], 0);
    chk("cont_g3", gq[3], 1);
`endif
    repeat (3) step();

    // Port 1 requests only during port 0's grant cycle, then withdraws.
    r0_we = 1'b0; r0_addr = 8'h30; r0_req = 1'b1;
    step();
    chk("wd_r0_gnt", r0_gnt, 1);
    r0_req = 1'b0;
    r1_we = 1'b1; r1_addr = 8'h31; r1_wdata = 8'hEE; r1_req = 1'b1;
    step();
    r1_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("wd_r1_gnt", r1_gnt, 0);
      chk("wd_mem_we", mem_we, 0);
      step();
    end
    chk("wd_ram", ram[8'h31], 8'h31 ^ 8'hA5);

    // Reset during a write grant: the write still lands, everything else clears.
    r0_we = 1'b1; r0_addr = 8'hF0; r0_wdata = 8'h77; r0_req = 1'b1;
    step();
    chk("rg_r0_gnt", r0_gnt, 1);
    chk("rg_mem_we", mem_we, 1);
    r0_req = 1'b0;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    chk("rg_ram", ram[8'hF0], 8'h77);
    chk("rg_busy", busy, 0);
    chk("rg_mem_we", mem_we, 0);
    chk("rg_mem_addr", mem_addr, 0);
    chk("rg_mem_wdata", mem_wdata, 0);
    step();
    chk("rg_no_rvalid", r0_rvalid, 0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
